ccu_recv_header_parser: RTL
===========================

# ccu_recv_header_parser

Parametrised successor to the CCU control-channel header receiver. It hunts for a sync byte on the CTRL byte stream, assembles little-endian ID, length and type fields of configurable width, and checks an optional 8-bit additive checksum. The decoded header is presented on registered outputs with a valid/ready handshake, and errors are reported explicitly. It sits between the CTRL byte receiver and the CCU payload/dispatch logic.

## Interface
- SYNC_BYTE, 8'h5A, start-of-header marker
- ID_BYTES, 2, pack_id width in bytes (1..4)
- LEN_BYTES, 2, pack_length width in bytes (1..4)
- TYPE_BYTES, 1, pack_type width in bytes (1..2)
- CHECKSUM_EN, 1, 1 = one checksum byte follows the type field
- TIMEOUT_CYCLES, 1024, maximum idle cycles between header bytes (≥2)

Ports:
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- recv_data  in  8  CTRL byte
- recv_en  in  1  recv_data valid this cycle
- hdr_valid  out  1  header fields valid
- hdr_ready  in  1  consumer accepts header
- pack_id  out  8*ID_BYTES  packet ID
- pack_length  out  8*LEN_BYTES  payload length
- pack_type  out  8*TYPE_BYTES  packet type
- int_recv_start  out  1  1-cycle pulse, sync accepted
- int_recv_finish  out  1  1-cycle pulse, header accepted into output regs
- int_recv_error  out  1  1-cycle pulse, header aborted
- err_code  out  2  last error: 0 none, 1 checksum, 2 timeout, 3 overflow; sticky until next error or reset

## Operation
- States: HUNT, ID, LEN, TYPE, CSUM (only if CHECKSUM_EN), COMMIT.
- HUNT: recv_en && recv_data==SYNC_BYTE → ID, clear byte counter, clear checksum accumulator, clear idle counter. Non-sync bytes are ignored.
- ID/LEN/TYPE: each recv_en byte is shifted into the shadow field at byte index = counter (LSB first) and added mod 256 to the accumulator. After N bytes the FSM goes to the next state with counter=0.
- CSUM: on recv_en, the byte must equal the accumulator. Mismatch → error 1, HUNT. Match → COMMIT.
- COMMIT (single cycle): if hdr_valid && !hdr_ready → error 3, header dropped, outputs untouched. Otherwise shadow fields are copied to outputs, hdr_valid=1, finish pulse. → HUNT.
- Timeout: in ID/LEN/TYPE/CSUM, the idle counter increments on each cycle without recv_en and resets on recv_en. Reaching TIMEOUT_CYCLES → error 2, HUNT.
- Handshake: hdr_valid falls on the cycle after hdr_valid && hdr_ready. The output fields stay stable while hdr_valid=1. Parsing of the next header continues while hdr_valid is pending.
- Reset values: all outputs 0, err_code 0, state HUNT. Asserting reset mid-header aborts with no error pulse.
- Sync byte value inside a header is treated as data; there is no resynchronisation.

## Timing
- int_recv_start: registered, high the cycle after the sync byte edge.
- hdr_valid and int_recv_finish: high 2 cycles after the final header byte edge (1 cycle to COMMIT, 1 registered).
- int_recv_error: registered, high the cycle after the detecting edge.
- If hdr_ready is asserted in the same cycle as COMMIT, it releases the old header first, so no overflow occurs and the new header loads.
- Consecutive headers may be back-to-back: the sync byte is accepted in the cycle after COMMIT.

## Structure
- Shared package ccu_recv_pkg: state enum, err_code constants (ERR_NONE/CSUM/TIMEOUT/OVFL), default SYNC_BYTE.
- Sub-module ccu_recv_idle_timer: parametrised idle counter with clear/enable inputs and an expired output. Width is $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Defaults, bytes 5A 34 12 10 00 07 5D, hdr_ready=1 → start pulse; pack_id=0x1234, pack_length=0x0010, pack_type=0x07, finish pulse; err_code=0.
- Same header with checksum byte 5C → int_recv_error, err_code=1, hdr_valid stays 0.
- 5A 34 followed by 1024 idle cycles → error pulse at idle cycle 1024, err_code=2; next valid header parses normally.
- Two valid headers with hdr_ready=0 → first held stable; second gives err_code=3; then hdr_ready=1 → first consumed, hdr_valid drops.
- ID_BYTES=4, LEN_BYTES=1, CHECKSUM_EN=0, bytes 5A 78 56 34 12 FF 03 → pack_id=0x12345678, pack_length=0xFF, pack_type=0x03.
- Reset asserted after 5A 34 12 → all outputs 0 asynchronously, no error pulse; after release, 00 5A... is hunted correctly.

Source files
------------

// File: rtl/ccu_recv_pkg.sv
// Shared types and constants for the CCU control-channel header receiver.
package ccu_recv_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_ID,
    ST_LEN,
    ST_TYPE,
    ST_CSUM,
    ST_COMMIT
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVFL    = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h5A;

endpackage

// File: rtl/ccu_recv_idle_timer.sv
// Idle-cycle counter: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches TIMEOUT_CYCLES.
module ccu_recv_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires combinationally during the idle cycle that would bring the count to TIMEOUT_CYCLES.
  assign expired_o = enable_i && !clear_i && (count_q == LAST);

endmodule

// File: rtl/ccu_recv_header_parser.sv
// CCU control-channel header receiver: sync hunt, little-endian field
// assembly, optional additive checksum and a valid/ready header output.
module ccu_recv_header_parser
  import ccu_recv_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned ID_BYTES       = 2,
  parameter int unsigned LEN_BYTES      = 2,
  parameter int unsigned TYPE_BYTES     = 1,
  parameter bit          CHECKSUM_EN    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [7:0]              recv_data,
  input  logic                    recv_en,
  output logic                    hdr_valid,
  input  logic                    hdr_ready,
  output logic [8*ID_BYTES-1:0]   pack_id,
  output logic [8*LEN_BYTES-1:0]  pack_length,
  output logic [8*TYPE_BYTES-1:0] pack_type,
  output logic                    int_recv_start,
  output logic                    int_recv_finish,
  output logic                    int_recv_error,
  output logic [1:0]              err_code
);

  localparam int unsigned ID_W   = 8 * ID_BYTES;
  localparam int unsigned LEN_W  = 8 * LEN_BYTES;
  localparam int unsigned TYPE_W = 8 * TYPE_BYTES;

  localparam logic [1:0] ID_LAST   = 2'(ID_BYTES - 1);
  localparam logic [1:0] LEN_LAST  = 2'(LEN_BYTES - 1);
  localparam logic [1:0] TYPE_LAST = 2'(TYPE_BYTES - 1);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [ID_W-1:0]   id_sh_q, id_sh_d;
  logic [LEN_W-1:0]  len_sh_q, len_sh_d;
  logic [TYPE_W-1:0] type_sh_q, type_sh_d;
  logic              hdr_valid_q, hdr_valid_d;
  logic [ID_W-1:0]   pack_id_q, pack_id_d;
  logic [LEN_W-1:0]  pack_len_q, pack_len_d;
  logic [TYPE_W-1:0] pack_type_q, pack_type_d;
  logic              start_q, start_d;
  logic              finish_q, finish_d;
  logic              error_q, error_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [7:0]        byte_sum;

  logic timer_clear, timer_enable, timer_expired;

  // The idle window only runs while a header is partially received.
  assign timer_clear  = recv_en || (state_q == ST_HUNT) || (state_q == ST_COMMIT);
  assign timer_enable = !timer_clear;

  ccu_recv_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk      (clk),
    .resetn   (resetn),
    .clear_i  (timer_clear),
    .enable_i (timer_enable),
    .expired_o(timer_expired)
  );

  assign byte_sum = csum_q + recv_data;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    id_sh_d     = id_sh_q;
    len_sh_d    = len_sh_q;
    type_sh_d   = type_sh_q;
    hdr_valid_d = hdr_valid_q;
    pack_id_d   = pack_id_q;
    pack_len_d  = pack_len_q;
    pack_type_d = pack_type_q;
    start_d     = 1'b0;
    finish_d    = 1'b0;
    error_d     = 1'b0;
    err_code_d  = err_code_q;

    // Release happens before COMMIT looks at hdr_valid, so a same-cycle ready frees the slot.
    if (hdr_valid_q && hdr_ready) begin
      hdr_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_HUNT: begin
        if (recv_en && (recv_data == SYNC_BYTE)) begin
          state_d = ST_ID;
          cnt_d   = 2'd0;
          csum_d  = 8'd0;
          start_d = 1'b1;
        end
      end

      ST_ID: begin
        if (recv_en) begin
          for (int b = 0; b < int'(ID_BYTES); b++) begin
            if (cnt_q == 2'(b)) id_sh_d[8*b +: 8] = recv_data;
          end
          csum_d = byte_sum;
          if (cnt_q == ID_LAST) begin
            cnt_d   = 2'd0;
            state_d = ST_LEN;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end

      ST_LEN: begin
        if (recv_en) begin
          for (int b = 0; b < int'(LEN_BYTES); b++) begin
            if (cnt_q == 2'(b)) len_sh_d[8*b +: 8] = recv_data;
          end
          csum_d = byte_sum;
          if (cnt_q == LEN_LAST) begin
            cnt_d   = 2'd0;
            state_d = ST_TYPE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end

      ST_TYPE: begin
        if (recv_en) begin
          for (int b = 0; b < int'(TYPE_BYTES); b++) begin
            if (cnt_q == 2'(b)) type_sh_d[8*b +: 8] = recv_data;
          end
          csum_d = byte_sum;
          if (cnt_q == TYPE_LAST) begin
            cnt_d   = 2'd0;
            state_d = CHECKSUM_EN ? ST_CSUM : ST_COMMIT;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end

      ST_CSUM: begin
        if (recv_en) begin
          if (recv_data == csum_q) begin
            state_d = ST_COMMIT;
          end else begin
            state_d    = ST_HUNT;
            error_d    = 1'b1;
            err_code_d = ERR_CSUM;
          end
        end
      end

      ST_COMMIT: begin
        state_d = ST_HUNT;
        if (hdr_valid_q && !hdr_ready) begin
          error_d    = 1'b1;
          err_code_d = ERR_OVFL;
        end else begin
          pack_id_d   = id_sh_q;
          pack_len_d  = len_sh_q;
          pack_type_d = type_sh_q;
          hdr_valid_d = 1'b1;
          finish_d    = 1'b1;
        end
      end

      default: state_d = ST_HUNT;
    endcase

    // Expiry only occurs on a cycle without recv_en, so it cannot collide with a byte.
    if (timer_expired) begin
      state_d    = ST_HUNT;
      error_d    = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_HUNT;
      cnt_q       <= 2'd0;
      csum_q      <= 8'd0;
      id_sh_q     <= '0;
      len_sh_q    <= '0;
      type_sh_q   <= '0;
      hdr_valid_q <= 1'b0;
      pack_id_q   <= '0;
      pack_len_q  <= '0;
      pack_type_q <= '0;
      start_q     <= 1'b0;
      finish_q    <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      id_sh_q     <= id_sh_d;
      len_sh_q    <= len_sh_d;
      type_sh_q   <= type_sh_d;
      hdr_valid_q <= hdr_valid_d;
      pack_id_q   <= pack_id_d;
      pack_len_q  <= pack_len_d;
      pack_type_q <= pack_type_d;
      start_q     <= start_d;
      finish_q    <= finish_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
    end
  end

  assign hdr_valid       = hdr_valid_q;
  assign pack_id         = pack_id_q;
  assign pack_length     = pack_len_q;
  assign pack_type       = pack_type_q;
  assign int_recv_start  = start_q;
  assign int_recv_finish = finish_q;
  assign int_recv_error  = error_q;
  assign err_code        = err_code_q;

endmodule
